// File: rtl/io_pad_arb_pkg.sv
// io_pad_arb_pkg: shared state type, synchronizer depth and counter sizing helper
//   for io_pad_arbiter and rr_arbiter.
package io_pad_arb_pkg;

   typedef enum logic [1:0] {IDLE, OWN, TURN} arbState_t;

   localparam int SYNC_STAGES = 2;

   // Bits needed to hold values 0..maxVal (never less than 1).
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first requester at or after ptr.
//   req     : request vector
//   ptr     : highest-priority index
//   pickOh  : one-hot winner (0 when no request)
//   pickIdx : binary index of the winner
module rr_arbiter
   import io_pad_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = cntWidth(N - 1)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  pickOh,
   output logic [IW-1:0] pickIdx
);

   // Scan from farthest to nearest so the requester closest to ptr overwrites the rest.
   always_comb begin
      int j;
      j = 0;
      pickOh = '0;
      pickIdx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % N;
         if (req[j]) begin
            pickOh = N'(1) << j;
            pickIdx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/io_pad_arbiter.sv
// io_pad_arbiter: round-robin owner of one bidirectional IO pad with enforced turnaround.
//   clk, rst              : clock, synchronous active-high reset
//   req/wr/dout [NREQ]    : per-requester request, direction (1=drive), drive data
//   gnt [NREQ]            : one-hot current owner, 0 outside a tenure
//   pad_c2p, pad_c2p_en   : registered drive data / output enable to the pad cell
//   pad_p2c               : asynchronous pad input
//   rd_data, rd_valid     : synchronized pad value, valid for a settled listening owner
//   lb_err                : sticky loopback mismatch, only with IO_PAD_ARB_LOOPBACK_CHK_EN
module io_pad_arbiter
   import io_pad_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int TURN_CYC = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] wr,
   input  logic [NREQ-1:0] dout,
   output logic [NREQ-1:0] gnt,
   output logic            pad_c2p,
   output logic            pad_c2p_en,
   input  logic            pad_p2c,
   output logic            rd_data,
   output logic            rd_valid
`ifdef IO_PAD_ARB_LOOPBACK_CHK_EN
   ,
   output logic            lb_err
`endif
);

   localparam int IW = cntWidth(NREQ - 1);
   // Age must reach 3 even for tiny MAX_HOLD so read-valid and loopback checks still work.
   localparam int HOLD_SAT = (MAX_HOLD < 3) ? 3 : MAX_HOLD;
   localparam int AW = cntWidth(HOLD_SAT);
   localparam int TW = cntWidth(TURN_CYC);

   arbState_t              state, stateNxt;
   logic [IW-1:0]          owner, ownerNxt, ptr, ptrNxt, pickIdx;
   logic [NREQ-1:0]        pickOh;
   logic                   ownWr, ownWrNxt, leave, driveNxt;
   logic [AW-1:0]          age, ageNxt;
   logic [TW-1:0]          turnCnt, turnNxt;
   logic [SYNC_STAGES-1:0] syncQ;

   rr_arbiter #(.N(NREQ), .IW(IW)) uArb (
      .req    (req),
      .ptr    (ptr),
      .pickOh (pickOh),
      .pickIdx(pickIdx)
   );

   // Pre-emption needs another requester waiting, so a lone owner keeps the pad.
   assign leave = !req[owner] || (age >= AW'(MAX_HOLD) && |(req & ~gnt));

   always_comb begin
      stateNxt = state;
      ownerNxt = owner;
      ownWrNxt = ownWr;
      ageNxt = age;
      turnNxt = turnCnt;
      ptrNxt = ptr;
      case (state)
         IDLE: if (|req) begin
            stateNxt = OWN;
            ownerNxt = pickIdx;
            ownWrNxt = |(wr & pickOh);
            ageNxt = AW'(1);
         end
         OWN: if (leave) begin
            stateNxt = (TURN_CYC == 0) ? IDLE : TURN;
            ptrNxt = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            turnNxt = TW'(1);
         end else if (age < AW'(HOLD_SAT)) begin
            ageNxt = age + 1'b1;
         end
         TURN: begin
            stateNxt = (turnCnt >= TW'(TURN_CYC)) ? IDLE : TURN;
            turnNxt = turnCnt + 1'b1;
         end
         default: stateNxt = IDLE;
      endcase
   end

   // Pad flops load from next-state so enable tracks gnt edge-for-edge.
   assign driveNxt = (stateNxt == OWN) && ownWrNxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         ownWr <= 1'b0;
         age <= '0;
         turnCnt <= '0;
         ptr <= '0;
         pad_c2p_en <= 1'b0;
         pad_c2p <= 1'b0;
         syncQ <= '0;
      end else begin
         state <= stateNxt;
         owner <= ownerNxt;
         ownWr <= ownWrNxt;
         age <= ageNxt;
         turnCnt <= turnNxt;
         ptr <= ptrNxt;
         pad_c2p_en <= driveNxt;
         pad_c2p <= driveNxt & dout[ownerNxt];
         syncQ <= {syncQ[SYNC_STAGES-2:0], pad_p2c};
      end
   end

   assign gnt = (state == OWN) ? (NREQ'(1) << owner) : '0;
   assign rd_data = syncQ[SYNC_STAGES-1];
   assign rd_valid = (state == OWN) && !ownWr && (age >= AW'(SYNC_STAGES));

`ifdef IO_PAD_ARB_LOOPBACK_CHK_EN
   // Driven value delayed to line up with the synchronizer output.
   logic [SYNC_STAGES-1:0] c2pDly;

   always_ff @(posedge clk) begin
      if (rst) begin
         c2pDly <= '0;
         lb_err <= 1'b0;
      end else begin
         c2pDly <= {c2pDly[SYNC_STAGES-2:0], pad_c2p};
         if (pad_c2p_en && age >= AW'(3) && rd_data != c2pDly[SYNC_STAGES-1]) lb_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_io_pad_arbiter.sv
// tb_io_pad_arbiter: scoreboard bench for io_pad_arbiter against a tenure-level model.
module tb_io_pad_arbiter;

   localparam int NREQ = 4;
   localparam int TURN_CYC = 2;
   localparam int MAX_HOLD = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NREQ-1:0] req = '0, wr = '0, dout = '0, gnt;
   logic            pad_c2p, pad_c2p_en, rd_data, rd_valid;
   logic            pad_p2c = 1'b0;
`ifdef IO_PAD_ARB_LOOPBACK_CHK_EN
   logic            lb_err;
`endif

   typedef struct packed {
      logic [NREQ-1:0] gnt;
      logic en, c2p, rdData, rdValid, lbErr;
   } exp_t;

   exp_t expQ[$];
   exp_t mon;
   int   checks = 0, failures = 0;

   // Model: owner -1 means pad free; gap counts remaining turnaround cycles.
   int mOwner = -1, mAge = 0, mGap = 0, mPtr = 0;
   bit mWr = 0, s1 = 0, s2 = 0, d1 = 0, d2 = 0, mLb = 0, mC2p = 0;

   always #5 clk = ~clk;

   io_pad_arbiter #(.NREQ(NREQ), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .wr        (wr),
      .dout      (dout),
      .gnt       (gnt),
      .pad_c2p   (pad_c2p),
      .pad_c2p_en(pad_c2p_en),
      .pad_p2c   (pad_p2c),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid)
`ifdef IO_PAD_ARB_LOOPBACK_CHK_EN
      ,
      .lb_err    (lb_err)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic modelStep();
      exp_t e;
      int   w;
      bit   leave;
      w = 0;
      if (rst) begin
         mOwner = -1; mAge = 0; mGap = 0; mPtr = 0; mWr = 0;
         s1 = 0; s2 = 0; d1 = 0; d2 = 0; mLb = 0; mC2p = 0;
      end else begin
         if (mOwner >= 0 && mWr && mAge >= 3 && s2 != d2) mLb = 1;
         d2 = d1; d1 = mC2p;
         s2 = s1; s1 = pad_p2c;
         if (mOwner >= 0) begin
            leave = !req[mOwner] || (mAge >= MAX_HOLD && (req & ~(NREQ'(1) << mOwner)) != 0);
            if (leave) begin
               mPtr = (mOwner + 1) % NREQ;
               mOwner = -1;
               mGap = TURN_CYC;
            end else mAge++;
         end else if (mGap > 0) begin
            mGap--;
         end else if (req != 0) begin
            for (int k = 0; k < NREQ; k++)
               if (req[(mPtr + k) % NREQ]) begin
                  w = (mPtr + k) % NREQ;
                  break;
               end
            mOwner = w; mWr = wr[w]; mAge = 1;
         end
      end
      mC2p = (mOwner >= 0 && mWr) ? dout[mOwner] : 1'b0;
      e.gnt = (mOwner >= 0) ? NREQ'(1) << mOwner : '0;
      e.en = mOwner >= 0 && mWr;
      e.c2p = mC2p;
      e.rdData = s2;
      e.rdValid = mOwner >= 0 && !mWr && mAge >= 2;
      e.lbErr = mLb;
      expQ.push_back(e);
   endtask

   // mode 0: pad mostly echoes what is driven; mode 1: pad random.
   task automatic drive(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] w,
                        input int mode);
      @(negedge clk);
      rst = r; req = rq; wr = w; dout = NREQ'($urandom);
      pad_p2c = (mode == 1 || $urandom_range(0, 15) == 0) ? 1'($urandom) : pad_c2p;
      modelStep();
   endtask

   always @(posedge clk) begin
      #1;
      if (expQ.size() != 0) begin
         mon = expQ.pop_front();
         check("gnt", gnt, mon.gnt);
         check("c2p_en", pad_c2p_en, mon.en);
         check("c2p", pad_c2p, mon.c2p);
         check("rd_data", rd_data, mon.rdData);
         check("rd_valid", rd_valid, mon.rdValid);
         check("gnt_onehot0", $onehot0(gnt), 1);
         check("en_without_gnt", pad_c2p_en && gnt == '0, 0);
`ifdef IO_PAD_ARB_LOOPBACK_CHK_EN
         check("lb_err", lb_err, mon.lbErr);
`endif
      end
   end

   initial begin
      logic [NREQ-1:0] rq, w;
      rq = '0; w = '0;
      repeat (2) drive(1, '0, '0, 0);
      repeat (5) drive(0, 4'b0010, 4'b0010, 0);
      drive(1, 4'b0010, 4'b0010, 0);
      repeat (4) drive(0, 4'b0010, 4'b0010, 0);
      repeat (4) drive(0, '0, '0, 0);
      repeat (40) drive(0, 4'b0100, 4'b0100, 0);
      repeat (4) drive(0, '0, '0, 0);
      repeat (4) drive(0, 4'b0001, 4'b1001, 0);
      repeat (4) drive(0, 4'b1001, 4'b1001, 0);
      repeat (10) drive(0, 4'b1000, 4'b1001, 0);
      repeat (4) drive(0, '0, '0, 0);
      repeat (100) drive(0, 4'b1111, NREQ'($urandom), 0);
      repeat (4) drive(0, '0, '0, 0);
      repeat (12) drive(0, 4'b0010, 4'b0000, 1);
      repeat (4) drive(0, '0, '0, 0);
      repeat (10) drive(0, 4'b0001, 4'b0001, 1);
      repeat (5) drive(0, '0, '0, 0);
      for (int n = 0; n < 2500; n++) begin
         for (int b = 0; b < NREQ; b++)
            if ($urandom_range(0, 11) == 0) rq[b] = ~rq[b];
         if ($urandom_range(0, 7) == 0) w = NREQ'($urandom);
         drive($urandom_range(0, 299) == 0, rq, w, ($urandom_range(0, 9) == 0) ? 1 : 0);
      end
      drive(0, '0, '0, 0);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/io_pad_arbiter.md
Name: io_pad_arbiter

Overview:
Shares one bidirectional IO pad (core-side c2p / c2p_en / p2c) among NREQ core requesters.
- Grants ownership round-robin; each owner either drives the pad or listens to it.
- Inserts enforced turnaround (pad undriven) between tenures so no two drivers overlap.
- Sits in the core between functional logic and the inout pad cell.

Parameters:
NREQ, 4, number of requesters (2..8)
TURN_CYC, 2, undriven turnaround cycles after each tenure (0..15)
MAX_HOLD, 16, tenure cycles after which owner is pre-empted if another req pending (>=1)

Ports:
clk  in  1  core clock
rst  in  1  reset, synchronous, active-high
req  in  NREQ  per-requester ownership request, level
wr  in  NREQ  per-requester direction: 1 = drive pad, 0 = listen; sampled at grant
dout  in  NREQ  per-requester data to drive
gnt  out  NREQ  one-hot grant; 0 when no tenure
pad_c2p  out  1  to pad cell c2p
pad_c2p_en  out  1  to pad cell c2p_en (output enable)
pad_p2c  in  1  from pad cell p2c (asynchronous)
rd_data  out  1  synchronized pad value
rd_valid  out  1  rd_data valid for a listening owner

Behaviour:
- Reset (clk edge with rst=1): state IDLE.
  - gnt=0, pad_c2p=0, pad_c2p_en=0, rd_data=0, rd_valid=0.
  - Round-robin pointer = 0 (requester 0 has highest priority first).
  - Sync flops = 0.
  - rst asserted mid-tenure releases the pad (c2p_en=0) on that same edge; no turnaround.
- States:
  - IDLE: pad undriven. If any req, pick winner W round-robin starting at pointer; next state OWN. Grant latency = 1 cycle from req seen.
  - OWN: gnt[W]=1. Latch wr[W] into own_wr at entry; own_wr is fixed for the whole tenure.
  - TURN: gnt=0, c2p_en=0 for TURN_CYC cycles, then go to IDLE arbitration logic in the same cycle. TURN_CYC=0 means OWN goes straight to IDLE.
- Leaving OWN: tenure ends when
  - req[W]=0, or
  - hold counter reaches MAX_HOLD and any other req is asserted.
  - Next state TURN. Pointer becomes W+1 mod NREQ.
  - A lone requester is never pre-empted; its hold counter saturates.
- Pad drive: registered, 1-cycle latency.
  - pad_c2p_en = (state==OWN) & own_wr.
  - pad_c2p = dout[W] registered while driving, else 0.
  - c2p_en falls on the same edge that gnt falls.
- Read path: 2-flop synchronizer on pad_p2c; rd_data = second flop.
  - rd_valid = 1 when in OWN with own_wr=0 and tenure age >= 2 cycles (synchronizer flushed).
  - Otherwise rd_valid = 0.
- Simultaneous events:
  - req drop and MAX_HOLD expiry in the same cycle: treated as a single exit.
  - A new req arriving during TURN: considered at the end of TURN.
  - A winner's req dropping during TURN or IDLE: not granted. Arbitration uses current req.
- Invariant: gnt is one-hot or zero; c2p_en=1 only while gnt!=0.

Optional Feature:
IO_PAD_ARB_LOOPBACK_CHK_EN
- Enabled adds output lb_err (1 bit, sticky, cleared only by rst).
  - While driving with tenure age >= 3, rd_data is compared with pad_c2p delayed 2 cycles.
  - Any mismatch sets lb_err. This detects a contended or shorted pad.
- Disabled: no port, no logic.

Decomposition:
- Package io_pad_arb_pkg holds:
  - state enum {IDLE, OWN, TURN};
  - SYNC_STAGES=2 constant;
  - width helper for the counters.
- Sub-module rr_arbiter (NREQ-wide, pointer-based round-robin one-hot picker, combinational) is instantiated once.
- Top-level keeps the FSM, counters, pad regs and synchronizer.

Test Plan:
- Reset mid-drive: req[1]=1, wr[1]=1 for 5 cycles, then rst=1 -> next edge gnt=0, c2p_en=0, rd_valid=0; after rst release req[1] still high -> gnt[1]=1 one cycle later.
- Single writer: req[2]=1, wr[2]=1, dout[2] toggling -> gnt=4'b0100 cycle+1; pad_c2p follows dout[2] with 1-cycle lag; c2p_en=1 throughout; never pre-empted past 16 cycles.
- Turnaround: req[0] writer drops after 4 cycles while req[3] pending -> c2p_en=0 exactly 2 cycles (TURN_CYC=2) + 1 IDLE cycle before gnt[3]; no cycle with gnt two-hot.
- Round-robin and pre-emption: all req=4'b1111 held -> grants cycle 0,1,2,3,0; each tenure is exactly 16 cycles.
- Listener: req[1]=1, wr[1]=0, pad_p2c driven 1,0,1 -> c2p_en=0; rd_valid rises on tenure cycle 2; rd_data equals pad_p2c delayed 2 cycles.
- Loopback (macro on): writer drives 1, bench forces pad_p2c=0 -> lb_err=1 within 3 cycles of age>=3; stays 1 after tenure ends; clears only on rst.
